matrix_loader: RTL and testbench
================================

// Module: matrix_loader
// PURPOSE
//  Upstream feeder for the systemizer. Accepts a stream of GF(M) matrix symbols over a valid/ready handshake.
//  Range-checks each symbol, packs BLOCK symbols per word and writes the L*K-symbol matrix into the systemizer
//  buffer via wr_en/wr_addr/wr_data. Then pulses sys_start and waits for the systemizer to finish.
//  Sits between the top-level pin interface and the systemizer write/start ports.
// PARAMETERS
//  L      8                       matrix rows
//  K      16                      matrix columns
//  M      3                       field size; legal symbol values are 0..M-1
//  BLOCK  4                       symbols per buffer word
//  SYM_W  `CLOG2(M) (=2)          symbol width, derived
//  DEPTH  (L*K)/BLOCK (=32)       buffer words, derived
//  AW     `CLOG2(DEPTH) (=5)      address width, derived
//  DW     BLOCK*SYM_W (=8)        word width, derived
// PORTS
//  clk        in   1      clock; all state changes on rising edge
//  rst_n      in   1      reset, synchronous, active-low
//  load_req   in   1      level; sampled in IDLE to begin a load
//  in_valid   in   1      symbol valid
//  in_data    in   SYM_W  symbol value
//  in_ready   out  1      symbol accepted when in_valid & in_ready
//  wr_en      out  1      buffer write strobe (one cycle per word)
//  wr_addr    out  AW     buffer word address
//  wr_data    out  DW     packed word; symbol j of the word is in bits [j*SYM_W +: SYM_W]
//  sys_start  out  1      one-cycle pulse to the systemizer start input
//  sys_done   in   1      systemizer done indication
//  busy       out  1      high in any state other than IDLE
//  err_sym    out  1      sticky: an out-of-range symbol aborted the last load
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): state=IDLE; in_ready, wr_en, sys_start, busy and err_sym are 0;
//    wr_addr=0, wr_data=0, and the symbol and word counters are 0.
//    Reset mid-operation aborts immediately: no further writes and no start pulse.
//  - FSM states: IDLE -> LOAD -> START -> WAIT -> IDLE.
//  - IDLE: in_ready=0. load_req=1 -> LOAD; this also clears err_sym and the counters.
//  - LOAD: in_ready=1 (never back-pressures, because writes cannot stall).
//    - Each accepted symbol is shifted into the pack register at slot sym_cnt (LSB first).
//    - Accepting the symbol that fills slot BLOCK-1 at edge t gives wr_en=1 for exactly one cycle after t.
//      wr_addr equals word_cnt and wr_data holds the full word. word_cnt then increments.
//    - Gaps in in_valid are allowed; counters hold while in_valid=0.
//  - Range check: an accepted symbol >= M sets err_sym=1 and forces the next state to IDLE.
//    No write is issued for the partial word, and no sys_start is issued.
//  - Last word: acceptance of symbol L*K-1 at edge t gives the final write (addr DEPTH-1) in cycle t+1.
//    in_ready=0 from t+1 onward, state=START in cycle t+1, and sys_start=1 in cycle t+2 only.
//  - START: drives sys_start for one cycle, then moves to WAIT.
//  - WAIT: in_ready=0; sys_done=1 -> IDLE. sys_done in any other state is ignored.
//  - load_req outside IDLE is ignored; it is not queued.
//  - Counter widths: sym_cnt is `CLOG2(BLOCK) bits; word_cnt is AW bits and is never allowed to wrap.
//  - wr_data and wr_addr hold their last value when wr_en=0.
// STRUCTURE
//  - Shared package/header: state encoding localparams (IDLE, LOAD, START, WAIT) and the derived
//    SYM_W/DEPTH/AW/DW expressions. These are shared with the systemizer instantiation at top level.
//  - One sub-module: symbol_packer, which holds the shift/pack register and sym_cnt,
//    and produces word_valid and word.
//  - FSM, word_cnt, range check and handshake logic live in matrix_loader.
// TESTING
//  1. load_req, then 128 symbols all =1 back-to-back -> 32 writes of 8'h55 at addr 0..31, one per 4 accepted
//     symbols; sys_start pulses once, 2 cycles after the last accept; busy stays 1 until sys_done.
//  2. First four symbols 0,1,2,0 -> first write addr 0, data 8'h24 (LSB-first packing verified).
//  3. Symbol value 3 at index 50 -> err_sym=1 next cycle; exactly 12 writes (addr 0..11);
//     no sys_start; returns to IDLE; next load_req clears err_sym.
//  4. rst_n=0 for one cycle after 70 symbols -> all outputs 0 the cycle after; a fresh load starts at addr 0.
//  5. in_valid toggling randomly (~50%) with 128 symbols -> same 32 words and addresses as a back-to-back load.
//  6. load_req held high during LOAD and WAIT -> no restart; after sys_done, a new load begins only if
//     load_req is still high in IDLE.

Source files
------------

// File: rtl/matrix_loader_pkg.sv
// Shared parameters, derived widths and FSM encoding for the matrix loader and the
// systemizer it feeds.
package matrix_loader_pkg;

    localparam int L     = 8;
    localparam int K     = 16;
    localparam int M     = 3;
    localparam int BLOCK = 4;

    localparam int SYM_W = $clog2(M);
    localparam int DEPTH = (L * K) / BLOCK;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = BLOCK * SYM_W;
    localparam int SC_W  = $clog2(BLOCK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_e;

    // A symbol is legal only when it names an element of GF(M).
    function automatic logic sym_in_range(input logic [SYM_W-1:0] s);
        return int'(s) < M;
    endfunction

endpackage

// File: rtl/matrix_loader_symbol_packer.sv
// Collects BLOCK symbols LSB-first into one buffer word and presents the finished
// word with a one-cycle word_valid strobe.
module matrix_loader_symbol_packer
    import matrix_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [SYM_W-1:0] sym_i,
    output logic [SC_W-1:0]  sym_cnt_o,
    output logic             word_valid_o,
    output logic [DW-1:0]    word_o
);

    logic [DW-1:0]   pack_q;
    logic [DW-1:0]   pack_d;
    logic [SC_W-1:0] sym_cnt_q;
    logic            word_valid_q;
    logic [DW-1:0]   word_q;
    logic            slot_last;

    always_comb begin
        pack_d = pack_q;
        pack_d[int'(sym_cnt_q) * SYM_W +: SYM_W] = sym_i;
    end

    assign slot_last = (sym_cnt_q == SC_W'(BLOCK - 1));

    // word_q is only loaded on completion, so it holds the last word between writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pack_q       <= '0;
            sym_cnt_q    <= '0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
        end else begin
            word_valid_q <= 1'b0;
            if (clear_i) begin
                pack_q    <= '0;
                sym_cnt_q <= '0;
            end else if (push_i) begin
                if (slot_last) begin
                    word_q       <= pack_d;
                    word_valid_q <= 1'b1;
                    pack_q       <= '0;
                    sym_cnt_q    <= '0;
                end else begin
                    pack_q    <= pack_d;
                    sym_cnt_q <= sym_cnt_q + SC_W'(1);
                end
            end
        end
    end

    assign sym_cnt_o    = sym_cnt_q;
    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/matrix_loader.sv
// Streams GF(M) symbols into the systemizer buffer one packed word at a time, then
// starts the systemizer and waits for it to finish.
module matrix_loader
    import matrix_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_req,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] in_data,
    output logic             in_ready,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [DW-1:0]    wr_data,
    output logic             sys_start,
    input  logic             sys_done,
    output logic             busy,
    output logic             err_sym
);

    state_e          state_q;
    logic            in_ready_q;
    logic            busy_q;
    logic            err_sym_q;
    logic            sys_start_q;
    logic [AW-1:0]   word_cnt_q;
    logic [AW-1:0]   wr_addr_q;

    logic            accept;
    logic            sym_ok;
    logic            push;
    logic            bad_sym;
    logic            start_load;
    logic            word_fill;
    logic            last_word;
    logic [SC_W-1:0] sym_cnt;
    logic            word_valid;
    logic [DW-1:0]   word;

    // in_ready is only high in LOAD, so acceptance implies the LOAD state.
    assign accept     = in_valid & in_ready_q;
    assign sym_ok     = sym_in_range(in_data);
    assign push       = accept & sym_ok;
    assign bad_sym    = accept & ~sym_ok;
    assign start_load = (state_q == IDLE) & load_req;
    assign word_fill  = push & (sym_cnt == SC_W'(BLOCK - 1));
    assign last_word  = word_fill & (word_cnt_q == AW'(DEPTH - 1));

    matrix_loader_symbol_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (start_load),
        .push_i       (push),
        .sym_i        (in_data),
        .sym_cnt_o    (sym_cnt),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_sym_q   <= 1'b0;
            sys_start_q <= 1'b0;
            word_cnt_q  <= '0;
            wr_addr_q   <= '0;
        end else begin
            sys_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_req) begin
                        state_q    <= LOAD;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        err_sym_q  <= 1'b0;
                        word_cnt_q <= '0;
                    end
                end
                LOAD: begin
                    // A bad symbol drops the partial word; the packer is cleared on the next load.
                    if (bad_sym) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        err_sym_q  <= 1'b1;
                    end else if (word_fill) begin
                        wr_addr_q <= word_cnt_q;
                        if (last_word) begin
                            state_q    <= START;
                            in_ready_q <= 1'b0;
                        end else begin
                            word_cnt_q <= word_cnt_q + AW'(1);
                        end
                    end
                end
                START: begin
                    sys_start_q <= 1'b1;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (sys_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign wr_en     = word_valid;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = word;
    assign sys_start = sys_start_q;
    assign busy      = busy_q;
    assign err_sym   = err_sym_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: table of load scenarios checked against a
// symbol-list reference model, plus reset, hold and error-clear sequences.
module tb_matrix_loader;
    import matrix_loader_pkg::*;

    localparam int NSYM = L * K;

    logic             clk;
    logic             rst_n;
    logic             load_req;
    logic             in_valid;
    logic [SYM_W-1:0] in_data;
    logic             in_ready;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             sys_start;
    logic             sys_done;
    logic             busy;
    logic             err_sym;

    matrix_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_req  (load_req),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .sys_start (sys_start),
        .sys_done  (sys_done),
        .busy      (busy),
        .err_sym   (err_sym)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pattern;     // 0: all ones, 1: random legal, 2: starts 0,1,2,0 then random
        int bad_idx;     // index replaced by value 3, or -1
        int gap_pct;     // percent of cycles with in_valid low
        int exp_writes;
        bit exp_start;
        bit exp_err;
    } vec_t;

    vec_t vecs[7];

    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0;
    int sym_q[$];
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] act_q[$];

    // scoreboard capture of buffer writes and start pulses
    always @(negedge clk) begin
        if (wr_en) act_q.push_back({wr_addr, wr_data});
        if (sys_start) start_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: every complete word before the first illegal symbol is written,
    // symbol j of word w weighted by 4**j; the load only starts the systemizer if clean.
    function automatic void build_exp();
        int bad = -1;
        int nwords;
        exp_q.delete();
        for (int i = 0; i < sym_q.size(); i++)
            if (bad < 0 && sym_q[i] >= M) bad = i;
        nwords = (bad < 0) ? DEPTH : bad / BLOCK;
        for (int w = 0; w < nwords; w++) begin
            int data = 0;
            int wt = 1;
            for (int j = 0; j < BLOCK; j++) begin
                data += sym_q[w * BLOCK + j] * wt;
                wt *= (1 << SYM_W);
            end
            exp_q.push_back({AW'(w), DW'(data)});
        end
    endfunction

    function automatic void build_syms(input int pattern, input int bad_idx);
        sym_q.delete();
        for (int i = 0; i < NSYM; i++)
            sym_q.push_back(pattern == 0 ? 1 : int'($urandom_range(M - 1)));
        if (pattern == 2) begin
            sym_q[0] = 0; sym_q[1] = 1; sym_q[2] = 2; sym_q[3] = 0;
        end
        if (bad_idx >= 0) sym_q[bad_idx] = 3;
    endfunction

    // driver: request a load and stream up to n symbols; stops after an illegal one
    task automatic do_load(input int n, input int gap_pct, input bit hold);
        int idx = 0;
        int cyc = 0;
        load_req = 1'b1;
        step();
        if (!hold) load_req = 1'b0;
        check("load_busy", 32'(busy), 32'd1);
        check("load_ready", 32'(in_ready), 32'd1);
        check("load_err_clr", 32'(err_sym), 32'd0);
        while (idx < n && cyc < 4000) begin
            logic rdy;
            rdy = in_ready;
            if (!rdy) break;
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = SYM_W'(sym_q[idx]);
            sys_done = 1'($urandom_range(1));
            step();
            cyc++;
            if (in_valid) begin
                idx++;
                if (sym_q[idx - 1] >= M) break;
            end
        end
        in_valid = 1'b0;
        sys_done = 1'b0;
        if (cyc >= 4000) check("load_timeout", 32'(cyc), 32'd0);
    endtask

    task automatic run_vector(input vec_t v, input bit hold);
        int starts0;
        build_syms(v.pattern, v.bad_idx);
        build_exp();
        act_q.delete();
        starts0 = start_cnt;
        do_load(NSYM, v.gap_pct, hold);
        if (v.exp_err) begin
            check("err_set", 32'(err_sym), 32'd1);
            check("err_ready", 32'(in_ready), 32'd0);
            check("err_busy", 32'(busy), 32'd0);
            check("err_no_partial", 32'(wr_en), 32'd0);
            repeat (4) step();
            check("err_sticky", 32'(err_sym), 32'd1);
        end else begin
            check("last_ready", 32'(in_ready), 32'd0);
            check("last_wr_en", 32'(wr_en), 32'd1);
            check("last_addr", 32'(wr_addr), DEPTH - 1);
            check("last_start_early", 32'(sys_start), 32'd0);
            step();
            check("start_pulse", 32'(sys_start), 32'd1);
            check("start_busy", 32'(busy), 32'd1);
            step();
            check("start_once", 32'(sys_start), 32'd0);
            check("wr_hold", 32'({wr_addr, wr_data}), 32'(exp_q[DEPTH - 1]));
            repeat ($urandom_range(4)) step();
            check("wait_busy", 32'(busy), 32'd1);
            sys_done = 1'b1;
            step();
            sys_done = 1'b0;
            check("done_idle", 32'(busy), 32'd0);
        end
        check("n_writes", act_q.size(), v.exp_writes);
        for (int i = 0; i < exp_q.size(); i++)
            if (i < act_q.size()) check("wr_word", 32'(act_q[i]), 32'(exp_q[i]));
        check("n_starts", start_cnt - starts0, 32'(v.exp_start));
        if (v.pattern == 2 && act_q.size() > 0)
            check("first_word_24", 32'(act_q[0]), 32'h024);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_sys_start"}, 32'(sys_start), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err_sym"}, 32'(err_sym), 32'd0);
    endtask

    initial begin
        int starts0;
        vecs[0] = '{0, -1,  0, 32, 1'b1, 1'b0};
        vecs[1] = '{2, -1,  0, 32, 1'b1, 1'b0};
        vecs[2] = '{0, 50,  0, 12, 1'b0, 1'b1};
        vecs[3] = '{1, -1, 50, 32, 1'b1, 1'b0};
        vecs[4] = '{1,  3, 30,  0, 1'b0, 1'b1};
        vecs[5] = '{1, 127, 0, 31, 1'b0, 1'b1};
        vecs[6] = '{2,  0, 20,  0, 1'b0, 1'b1};

        rst_n = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = '0; sys_done = 1'b0;
        step();
        step();
        check_all_zero("rst");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_vector(vecs[i], 1'b0);

        // load_req held through LOAD and WAIT: no restart mid-load, restart from IDLE
        run_vector(vecs[0], 1'b1);
        step();
        check("hold_restart_busy", 32'(busy), 32'd1);
        check("hold_restart_ready", 32'(in_ready), 32'd1);
        load_req = 1'b0;
        in_valid = 1'b1;
        in_data  = 2'd3;
        step();
        in_valid = 1'b0;
        check("bad_first_err", 32'(err_sym), 32'd1);
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        check("next_load_clears_err", 32'(err_sym), 32'd0);

        // reset after 70 symbols, then a fresh load from address 0
        build_syms(1, -1);
        act_q.delete();
        do_load(70, 0, 1'b0);
        check("mid_writes", act_q.size(), 32'd17);
        rst_n = 1'b0;
        step();
        check_all_zero("mid_rst");
        rst_n = 1'b1;
        act_q.delete();
        starts0 = start_cnt;
        repeat (3) step();
        check("post_rst_no_write", act_q.size(), 32'd0);
        check("post_rst_no_start", start_cnt - starts0, 32'd0);
        run_vector(vecs[3], 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
